// File: rtl/spi_dac_driver.sv
// spi_dac_driver: serialises 8-bit DDS samples into 16-bit SPI DAC frames with a
// one-deep latest-wins pending register and a saturating dropped-sample counter.
module spi_dac_driver #(
    parameter int          SCLK_HALF = 1,
    parameter int          CS_HIGH   = 2,
    parameter logic [3:0]  CTRL_BITS = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    localparam logic [3:0] HL = 4'(SCLK_HALF - 1);
    localparam logic [3:0] CL = 4'(CS_HIGH - 1);
    state_t      state, state_n;
    logic [3:0]  hcnt, hcnt_n, bcnt, bcnt_n;
    logic [15:0] shreg, shreg_n, drop_n;
    logic [7:0]  pend, pend_n;
    logic        pend_v, pend_v_n, cs_n_n, sclk_n, din_n, fd_n;
    logic        last_hold, start, drop_inc;
    always_comb begin
        last_hold = state == HOLD && hcnt == CL;
        start     = (state == IDLE && sample_valid) || (last_hold && (sample_valid || pend_v));
        drop_inc  = sample_valid && pend_v && state != IDLE;
        drop_n    = (drop_inc && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
        pend_n    = pend;
        pend_v_n  = pend_v;
        if (last_hold) begin
            pend_v_n = 1'b0;
        end else if (sample_valid && state != IDLE) begin
            pend_n   = sample_in;
            pend_v_n = 1'b1;
        end
        state_n = state;
        hcnt_n  = hcnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        cs_n_n  = dac_cs_n;
        sclk_n  = dac_sclk;
        din_n   = dac_din;
        if (start) begin
            state_n = SHIFT;
            hcnt_n  = 4'd0;
            bcnt_n  = 4'd0;
            shreg_n = {CTRL_BITS, sample_valid ? sample_in : pend, 4'b0000};
            cs_n_n  = 1'b0;
            sclk_n  = 1'b0;
            din_n   = CTRL_BITS[3];
        end else if (state == SHIFT) begin
            hcnt_n = hcnt + 4'd1;
            if (hcnt == HL) begin
                hcnt_n = 4'd0;
                sclk_n = ~dac_sclk;
                // data only moves on the falling edge so the DAC samples a stable bit
                if (dac_sclk && bcnt == 4'd15) begin
                    state_n = HOLD;
                    cs_n_n  = 1'b1;
                    din_n   = 1'b0;
                end else if (dac_sclk) begin
                    bcnt_n  = bcnt + 4'd1;
                    shreg_n = shreg << 1;
                    din_n   = shreg[14];
                end
            end
        end else if (state == HOLD) begin
            hcnt_n  = hcnt + 4'd1;
            state_n = last_hold ? IDLE : HOLD;
        end
        fd_n = state_n == HOLD && hcnt_n == CL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hcnt       <= 4'd0;
            bcnt       <= 4'd0;
            shreg      <= 16'd0;
            pend       <= 8'd0;
            pend_v     <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            drop_cnt   <= 16'd0;
        end else begin
            state      <= state_n;
            hcnt       <= hcnt_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            pend       <= pend_n;
            pend_v     <= pend_v_n;
            dac_cs_n   <= cs_n_n;
            dac_sclk   <= sclk_n;
            dac_din    <= din_n;
            busy       <= state_n != IDLE;
            frame_done <= fd_n;
            drop_cnt   <= drop_n;
        end
    end
endmodule

// File: tb/tb_spi_dac_driver.sv
// tb_spi_dac_driver: default and (3,1,9) instances checked every cycle against a
// frame-timing reference model plus directed checks of captured frame words.
module tb_spi_dac_driver;
    typedef struct {
        bit          active;
        int          start;
        logic [15:0] word;
        logic [7:0]  pend;
        bit          pv;
        logic [15:0] drops;
    } model_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sv[2];
    logic [7:0]  smp[2];
    logic        cs_o[2], sclk_o[2], din_o[2], busy_o[2], fd_o[2];
    logic [15:0] drop_o[2];
    int          checks = 0, errors = 0, cyc = 0;
    int          h_a[2] = '{1, 3};
    int          c_a[2] = '{2, 1};
    logic [3:0]  ctrl_a[2] = '{4'h0, 4'h9};
    model_t      m[2];
    logic [15:0] cap[2], lastw[2];
    logic        prev_cs[2] = '{1'b1, 1'b1};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    int          blen[2] = '{0, 0};
    int          blast[2] = '{0, 0};
    bit          force_now[2] = '{1'b0, 1'b0};
    always #5 clk = ~clk;
    spi_dac_driver dut (
        .clk(clk), .rst_n(rst_n), .sample_in(smp[0]), .sample_valid(sv[0]),
        .dac_cs_n(cs_o[0]), .dac_sclk(sclk_o[0]), .dac_din(din_o[0]),
        .busy(busy_o[0]), .frame_done(fd_o[0]), .drop_cnt(drop_o[0])
    );
    spi_dac_driver #(.SCLK_HALF(3), .CS_HIGH(1), .CTRL_BITS(4'h9)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_in(smp[1]), .sample_valid(sv[1]),
        .dac_cs_n(cs_o[1]), .dac_sclk(sclk_o[1]), .dac_din(din_o[1]),
        .busy(busy_o[1]), .frame_done(fd_o[1]), .drop_cnt(drop_o[1])
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    function automatic logic [15:0] sat_inc(input logic [15:0] d);
        return d == 16'hFFFF ? d : d + 16'd1;
    endfunction
    // Reference: a frame is a start cycle plus a word; everything else is arithmetic on the offset.
    task automatic step(input int i, input logic v, input logic [7:0] s);
        int flen;
        flen = 32 * h_a[i] + c_a[i];
        if (!m[i].active) begin
            if (v) begin m[i].active = 1; m[i].start = cyc + 1; m[i].word = {ctrl_a[i], s, 4'h0}; end
        end else if (cyc == m[i].start + flen - 1) begin
            if (v) begin
                if (m[i].pv) m[i].drops = sat_inc(m[i].drops);
                m[i].start = cyc + 1; m[i].word = {ctrl_a[i], s, 4'h0};
            end else if (m[i].pv) begin
                m[i].start = cyc + 1; m[i].word = {ctrl_a[i], m[i].pend, 4'h0};
            end else m[i].active = 0;
            m[i].pv = 0;
        end else if (v) begin
            if (m[i].pv) m[i].drops = sat_inc(m[i].drops);
            m[i].pend = s; m[i].pv = 1;
        end
    endtask
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int o, hh;
            logic e_cs, e_sclk, e_din, e_busy, e_fd;
            hh = h_a[i];
            if (!rst_n) begin
                m[i] = '{default: 0};
                prev_cs[i] = 1'b1;
                prev_sclk[i] = 1'b0;
            end
            if (force_now[i]) m[i].drops = 16'hFFFE;
            e_cs = 1; e_sclk = 0; e_din = 0; e_busy = 0; e_fd = 0;
            if (m[i].active && cyc >= m[i].start) begin
                o = cyc - m[i].start;
                e_busy = 1;
                if (o < 32 * hh) begin
                    e_cs = 0;
                    e_sclk = (o % (2 * hh)) >= hh;
                    e_din = m[i].word[15 - o / (2 * hh)];
                end else e_fd = (o == 32 * hh + c_a[i] - 1);
            end
            check($sformatf("cs_n%0d", i), 32'(cs_o[i]), 32'(e_cs));
            check($sformatf("sclk%0d", i), 32'(sclk_o[i]), 32'(e_sclk));
            check($sformatf("din%0d", i), 32'(din_o[i]), 32'(e_din));
            check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(e_busy));
            check($sformatf("frame_done%0d", i), 32'(fd_o[i]), 32'(e_fd));
            check($sformatf("drop_cnt%0d", i), 32'(drop_o[i]), 32'(m[i].drops));
            if (sclk_o[i] && !prev_sclk[i]) cap[i] = {cap[i][14:0], din_o[i]};
            if (rst_n && cs_o[i] && !prev_cs[i]) begin
                check($sformatf("frame_word%0d", i), 32'(cap[i]), 32'(m[i].word));
                lastw[i] = cap[i];
            end
            if (busy_o[i]) blen[i]++;
            else if (blen[i] > 0) begin blast[i] = blen[i]; blen[i] = 0; end
            prev_cs[i] = cs_o[i];
            prev_sclk[i] = sclk_o[i];
            if (rst_n) step(i, sv[i], smp[i]);
        end
        cyc++;
    end
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic pulse(input int i, input logic [7:0] s);
        sv[i] = 1'b1; smp[i] = s;
        @(posedge clk); #1;
        sv[i] = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        sv = '{1'b0, 1'b0};
        smp = '{8'h00, 8'h00};
        idle(3);
        rst_n = 1'b1;
        idle(2);
        pulse(0, 8'hA5);
        idle(40);
        check("word_a5", 32'(lastw[0]), 32'h0A50);
        check("busy_len_default", blast[0], 34);
        check("drop_single", 32'(drop_o[0]), 0);
        pulse(0, 8'h11); idle(4); pulse(0, 8'h22);
        idle(80);
        check("word_b2b", 32'(lastw[0]), 32'h0220);
        check("busy_len_b2b", blast[0], 68);
        check("drop_b2b", 32'(drop_o[0]), 0);
        pulse(0, 8'h11); idle(2); pulse(0, 8'h22); idle(2); pulse(0, 8'h33);
        idle(80);
        check("word_overwrite", 32'(lastw[0]), 32'h0330);
        check("drop_overwrite", 32'(drop_o[0]), 1);
        pulse(0, 8'h11); idle(2); pulse(0, 8'h44); idle(30); pulse(0, 8'h55);
        idle(80);
        check("word_collision", 32'(lastw[0]), 32'h0550);
        check("drop_collision", 32'(drop_o[0]), 2);
        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                sv[i] = ($urandom_range(0, 7) == 0);
                smp[i] = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        sv = '{1'b0, 1'b0};
        idle(150);
        pulse(0, 8'h77);
        idle(15);
        rst_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs_o[0]), 1);
        check("rst_sclk", 32'(sclk_o[0]), 0);
        check("rst_din", 32'(din_o[0]), 0);
        check("rst_busy", 32'(busy_o[0]), 0);
        check("rst_drop", 32'(drop_o[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        pulse(0, 8'h5A);
        idle(40);
        check("word_after_reset", 32'(lastw[0]), 32'h05A0);
        pulse(1, 8'hFF);
        idle(100);
        check("word_param", 32'(lastw[1]), 32'h9FF0);
        check("busy_len_param", blast[1], 97);
        force_now[1] = 1'b1;
        force dut2.drop_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut2.drop_cnt;
        force_now[1] = 1'b0;
        check("drop_forced", 32'(drop_o[1]), 32'hFFFE);
        pulse(1, 8'h01); pulse(1, 8'h02); pulse(1, 8'h03); pulse(1, 8'h04);
        idle(220);
        check("drop_saturate", 32'(drop_o[1]), 32'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
